// File: rtl/pll_lock_monitor.sv
// ============================================================================
// Module   : pll_lock_monitor
// Brief    : Measures clockp cycles per osc period and validates PLL lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pll_lock_monitor #(
  parameter int CNT_W    = 8,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 16
) (
  input  logic             clockp,
  input  logic             reset,
  input  logic             enable,
  input  logic             osc,
  input  logic [4:0]       div,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt,
  output logic             ovf,
  output logic             locked
);

  localparam int               RUN_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W:0]   C_TOL      = (CNT_W + 1)'(TOL);
  localparam logic [RUN_W-1:0] C_RUN_LAST = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] C_RUN_FULL = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_edge;
  logic [4:0]         r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic [RUN_W-1:0]   r_run;
  logic [RUN_W-1:0]   w_run_nxt;
  logic               w_locked_nxt;
  logic               w_osc_rise;
  logic               w_div_chg;
  logic               w_active;
  logic               w_meas;
  logic               w_arm_hit;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]     w_absd;
  logic               w_good;

  assign w_osc_rise = r_sync2 & ~r_edge;
  assign w_active   = enable & ((r_state == S_TRACK) | (r_state == S_LOCKED));
  assign w_div_chg  = w_active & (div != r_div);
  assign w_meas     = w_active & w_osc_rise;
  assign w_arm_hit  = enable & (r_state == S_ARM) & w_osc_rise;

  // Signed distance of the count from the expected ratio; div is zero-extended.
  assign w_diff = $signed({1'b0, r_cnt}) - $signed({{(CNT_W - 4){1'b0}}, r_div});
  assign w_absd = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_good = ~r_sat & (w_absd <= C_TOL);

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_locked_nxt = locked;
    if (!enable) begin
      w_state_nxt  = S_IDLE;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_ARM;
          w_locked_nxt = 1'b0;
        end
        S_ARM: begin
          w_locked_nxt = 1'b0;
          if (w_osc_rise) begin
            w_state_nxt = S_TRACK;
            w_run_nxt   = '0;
          end
        end
        S_TRACK: begin
          w_locked_nxt = 1'b0;
          if (w_div_chg) begin
            w_run_nxt = '0;
          end else if (w_meas) begin
            if (!w_good) begin
              w_run_nxt = '0;
            end else begin
              w_run_nxt = r_run + 1'b1;
              if (r_run == C_RUN_LAST) begin
                w_state_nxt = S_LOCKED;
              end
            end
          end
        end
        S_LOCKED: begin
          w_locked_nxt = 1'b1;
          if (w_div_chg || (w_meas && !w_good)) begin
            w_state_nxt  = S_TRACK;
            w_run_nxt    = '0;
            w_locked_nxt = 1'b0;
          end else if (w_meas && (r_run != C_RUN_FULL)) begin
            w_run_nxt = r_run + 1'b1;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clockp) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_run   <= '0;
      locked  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      locked  <= w_locked_nxt;
    end
  end

  always_ff @(posedge clockp) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_edge     <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      min_cnt    <= '1;
      max_cnt    <= '0;
      ovf        <= 1'b0;
    end else begin
      r_sync1    <= osc;
      r_sync2    <= r_sync1;
      r_edge     <= r_sync2;
      r_div      <= div;
      meas_valid <= w_meas;

      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_osc_rise) begin
        r_cnt <= CNT_W'(1);
        r_sat <= 1'b0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_arm_hit) begin
        min_cnt <= '1;
        max_cnt <= '0;
      end

      // Saturated counts still feed min/max so a stalled osc is visible.
      if (w_meas) begin
        period_cnt <= r_cnt;
        ovf        <= r_sat;
        if (r_cnt < min_cnt) begin
          min_cnt <= r_cnt;
        end
        if (r_cnt > max_cnt) begin
          max_cnt <= r_cnt;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
// ============================================================================
// Module   : tb_pll_lock_monitor
// Brief    : Scoreboard bench for pll_lock_monitor with clockp-aligned osc.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_monitor;

  logic       clockp = 1'b0;
  logic       reset;
  logic       enable;
  logic       osc;
  logic [4:0] div;
  logic [7:0] period_cnt;
  logic       meas_valid;
  logic [7:0] min_cnt;
  logic [7:0] max_cnt;
  logic       ovf;
  logic       locked;

  pll_lock_monitor #(.CNT_W(8), .TOL(1), .LOCK_CNT(16)) u_dut (
    .clockp     (clockp),
    .reset      (reset),
    .enable     (enable),
    .osc        (osc),
    .div        (div),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .min_cnt    (min_cnt),
    .max_cnt    (max_cnt),
    .ovf        (ovf),
    .locked     (locked)
  );

  always #5 clockp = ~clockp;

  typedef struct {
    int cnt;
    bit ovf;
    bit lnow;
    bit lnext;
    int mn;
    int mx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_edge = 0;
  bit   have_prev = 0;
  int   run = 0;
  bit   mlock = 0;
  int   mmin = 255;
  int   mmax = 0;
  int   mdiv = 10;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clockp);
    cyc++;
  end

  // Raise osc and predict what the DUT reports for the period just closed.
  task automatic osc_edge();
    int   len;
    int   c;
    int   d;
    bit   sat;
    bit   good;
    exp_t e;
    len = cyc - last_edge;
    if (have_prev) begin
      sat = (len > 255);
      c   = sat ? 255 : len;
      d   = len - mdiv;
      if (d < 0) d = -d;
      good   = !sat && (d <= 1);
      e.cnt  = c;
      e.ovf  = sat;
      e.lnow = good ? mlock : 1'b0;
      if (good) begin
        if (!mlock) begin
          run++;
          if (run == 16) mlock = 1'b1;
        end
      end else begin
        run   = 0;
        mlock = 1'b0;
      end
      e.lnext = mlock;
      if (c < mmin) mmin = c;
      if (c > mmax) mmax = c;
      e.mn = mmin;
      e.mx = mmax;
      q.push_back(e);
    end else begin
      have_prev = 1'b1;
      mmin = 255;
      mmax = 0;
      run  = 0;
    end
    last_edge = cyc;
    osc = 1'b1;
  endtask

  task automatic run_osc(input int n);
    osc_edge();
    repeat (n / 2) @(negedge clockp);
    osc = 1'b0;
    repeat (n - n / 2) @(negedge clockp);
  endtask

  task automatic set_div(input int v);
    if (v != mdiv) begin
      run   = 0;
      mlock = 1'b0;
    end
    mdiv = v;
    div  = 5'(v);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_period"}, period_cnt, 0);
    check_val({tag, "_mvalid"}, meas_valid, 0);
    check_val({tag, "_min"}, min_cnt, 255);
    check_val({tag, "_max"}, max_cnt, 0);
    check_val({tag, "_ovf"}, ovf, 0);
    check_val({tag, "_locked"}, locked, 0);
  endtask

  // Monitor: pop on every meas_valid, then check locked one cycle later.
  initial begin
    bit   chk_next;
    bit   nxt_val;
    exp_t e;
    chk_next = 1'b0;
    nxt_val  = 1'b0;
    forever begin
      @(negedge clockp);
      if (chk_next) begin
        check_val("lock_next", locked, nxt_val);
        chk_next = 1'b0;
      end
      if (meas_valid === 1'b1) begin
        if (q.size() == 0) begin
          check_val("spurious_meas", 1, 0);
        end else begin
          e = q.pop_front();
          check_val("period_cnt", period_cnt, e.cnt);
          check_val("ovf", ovf, e.ovf);
          check_val("lock_now", locked, e.lnow);
          check_val("min_cnt", min_cnt, e.mn);
          check_val("max_cnt", max_cnt, e.mx);
          chk_next = 1'b1;
          nxt_val  = e.lnext;
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired actual=%0d expected=0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    osc    = 1'b0;
    div    = 5'd10;
    repeat (2) @(negedge clockp);
    check_reset_vals("rst0");
    reset  = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clockp);

    // Nominal lock at div=10.
    repeat (18) run_osc(10);
    check_val("t1_locked", locked, 1);

    // One stretched period breaks lock, then relock.
    run_osc(13);
    repeat (17) run_osc(10);

    // div=9 stays inside tolerance, div=12 does not.
    set_div(9);
    @(negedge clockp);
    check_val("div9_unlock", locked, 0);
    repeat (18) run_osc(10);
    set_div(12);
    @(negedge clockp);
    check_val("div12_unlock", locked, 0);
    repeat (20) run_osc(10);
    check_val("div12_nolock", locked, 0);
    set_div(10);
    repeat (18) run_osc(10);

    // osc stall: lock holds until the saturated measurement arrives.
    osc_edge();
    repeat (5) @(negedge clockp);
    osc = 1'b0;
    repeat (285) @(negedge clockp);
    check_val("stall_lock_hold", locked, 1);
    check_val("stall_period_hold", period_cnt, 10);
    repeat (10) @(negedge clockp);
    repeat (18) run_osc(10);

    // Enable drop while locked: outputs hold, re-arm reinitialises min/max.
    enable = 1'b0;
    have_prev = 1'b0;
    run   = 0;
    mlock = 1'b0;
    @(negedge clockp);
    check_val("dis_locked", locked, 0);
    check_val("dis_mvalid", meas_valid, 0);
    check_val("dis_period", period_cnt, 10);
    check_val("dis_min", min_cnt, mmin);
    check_val("dis_max", max_cnt, mmax);
    repeat (5) @(negedge clockp);
    check_val("dis_ovf", ovf, 0);
    enable = 1'b1;
    repeat (2) @(negedge clockp);
    run_osc(10);
    check_val("rearm_min", min_cnt, 255);
    check_val("rearm_max", max_cnt, 0);
    repeat (17) run_osc(10);
    check_val("rearm_locked", locked, 1);

    // Reset mid-period while locked, osc low.
    osc_edge();
    repeat (5) @(negedge clockp);
    osc = 1'b0;
    repeat (2) @(negedge clockp);
    reset = 1'b1;
    @(negedge clockp);
    check_reset_vals("rst1");
    reset = 1'b0;
    have_prev = 1'b0;
    run   = 0;
    mlock = 1'b0;
    repeat (3) @(negedge clockp);
    repeat (18) run_osc(10);
    check_val("rst1_relock", locked, 1);

    repeat (5) @(negedge clockp);
    check_val("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
